// File: rtl/mag_window_stats.sv
// Windowed statistics (floor average, peak, minimum, over-threshold count) over the magnitude stream.
// Optional alarm release hysteresis is enabled by defining MAG_ALARM_HYST_EN.
module mag_window_stats #(
   parameter int          WIN_LOG2 = 3,
   parameter logic [7:0]  HYST     = 8'd4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          mag_in,
   input  logic                mag_valid,
   input  logic [7:0]          thresh,
   output logic                stats_valid,
   input  logic                stats_ready,
   output logic [7:0]          avg_out,
   output logic [7:0]          peak_out,
   output logic [7:0]          min_out,
   output logic [WIN_LOG2:0]   over_cnt,
   output logic                overrun,
   output logic                alarm
);

   localparam int SUM_W = 8 + WIN_LOG2;
   localparam logic [WIN_LOG2-1:0] IDX_ONE = 1;

   logic [SUM_W-1:0]    sum, sum_nxt;
   logic [7:0]          run_max, run_min, max_nxt, min_nxt, avg_nxt;
   logic [WIN_LOG2:0]   run_cnt, cnt_nxt;
   logic [WIN_LOG2-1:0] idx;
   logic                last, handshake, alarm_nxt;

   // Result port: a result transfers on any edge where stats_valid and stats_ready are both 1;
   // stats_valid never drops without that transfer, and a newer window may overwrite a stalled one.
   always_comb begin
      sum_nxt   = sum + SUM_W'(mag_in);
      max_nxt   = (mag_in > run_max) ? mag_in : run_max;
      min_nxt   = (mag_in < run_min) ? mag_in : run_min;
      cnt_nxt   = run_cnt + {{WIN_LOG2{1'b0}}, (mag_in >= thresh)};
      last      = mag_valid && (idx == '1);
      avg_nxt   = sum_nxt[SUM_W-1:WIN_LOG2];
      handshake = stats_valid && stats_ready;
   end

`ifdef MAG_ALARM_HYST_EN
   logic [7:0] release_lvl;
   always_comb begin
      release_lvl = (thresh > HYST) ? (thresh - HYST) : 8'd0;
      alarm_nxt   = alarm;
      if (avg_nxt >= thresh)
         alarm_nxt = 1'b1;
      else if (avg_nxt < release_lvl)
         alarm_nxt = 1'b0;
   end
`else
   logic unused_hyst;
   assign unused_hyst = ^HYST;
   always_comb alarm_nxt = (avg_nxt >= thresh);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sum         <= '0;
         run_max     <= 8'h00;
         run_min     <= 8'hFF;
         run_cnt     <= '0;
         idx         <= '0;
         stats_valid <= 1'b0;
         avg_out     <= 8'h00;
         peak_out    <= 8'h00;
         min_out     <= 8'h00;
         over_cnt    <= '0;
         overrun     <= 1'b0;
         alarm       <= 1'b0;
      end else begin
         if (last) begin
            sum     <= '0;
            run_max <= 8'h00;
            run_min <= 8'hFF;
            run_cnt <= '0;
            idx     <= '0;
         end else if (mag_valid) begin
            sum     <= sum_nxt;
            run_max <= max_nxt;
            run_min <= min_nxt;
            run_cnt <= cnt_nxt;
            idx     <= idx + IDX_ONE;
         end

         if (last) begin
            avg_out     <= avg_nxt;
            peak_out    <= max_nxt;
            min_out     <= min_nxt;
            over_cnt    <= cnt_nxt;
            alarm       <= alarm_nxt;
            stats_valid <= 1'b1;
         end else if (handshake) begin
            stats_valid <= 1'b0;
         end

         // A completion on the handshake edge replaces the result cleanly, so overrun is untouched.
         if (last && stats_valid && !stats_ready)
            overrun <= 1'b1;
         else if (handshake && !last)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed bench for mag_window_stats with a reference model feeding an expected-result queue.
module tb_mag_window_stats;

   localparam int         WIN_LOG2 = 3;
   localparam int         WIN      = 1 << WIN_LOG2;
   localparam logic [7:0] HYST     = 8'd4;
   localparam int         RES_W    = 8 + 8 + 8 + (WIN_LOG2 + 1) + 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [7:0]         mag_in;
   logic               mag_valid;
   logic [7:0]         thresh;
   logic               stats_valid;
   logic               stats_ready;
   logic [7:0]         avg_out, peak_out, min_out;
   logic [WIN_LOG2:0]  over_cnt;
   logic               overrun;
   logic               alarm;

   logic [RES_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fails  = 0;

   int m_sum, m_max, m_min, m_cnt, m_n;
   logic m_alarm;

   mag_window_stats #(.WIN_LOG2(WIN_LOG2), .HYST(HYST)) dut (
      .clk(clk), .rst(rst), .mag_in(mag_in), .mag_valid(mag_valid), .thresh(thresh),
      .stats_valid(stats_valid), .stats_ready(stats_ready), .avg_out(avg_out),
      .peak_out(peak_out), .min_out(min_out), .over_cnt(over_cnt), .overrun(overrun),
      .alarm(alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_clear();
      m_sum = 0; m_max = 0; m_min = 255; m_cnt = 0; m_n = 0;
   endtask

   task automatic model_add(input logic [7:0] m);
      int avg;
      m_sum += int'(m);
      if (int'(m) > m_max) m_max = int'(m);
      if (int'(m) < m_min) m_min = int'(m);
      if (m >= thresh) m_cnt++;
      m_n++;
      if (m_n == WIN) begin
         avg = m_sum / WIN;
`ifdef MAG_ALARM_HYST_EN
         if (avg >= int'(thresh)) m_alarm = 1'b1;
         else if (avg < int'(thresh) - int'(HYST)) m_alarm = 1'b0;
`else
         m_alarm = (avg >= int'(thresh));
`endif
         exp_q.push_back({8'(avg), 8'(m_max), 8'(m_min), 4'(m_cnt), m_alarm});
         model_clear();
      end
   endtask

   task automatic send(input logic [7:0] m);
      mag_in    = m;
      mag_valid = 1'b1;
      model_add(m);
      @(posedge clk);
      #1;
      mag_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      mag_valid = 1'b1;
      mag_in    = 8'd200;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      mag_valid = 1'b0;
      model_clear();
      m_alarm = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_result(input string tag);
      logic [RES_W-1:0] e;
      int w = 0;
      while (!stats_valid && w < 20) begin
         idle(1);
         w++;
      end
      check({tag, "_valid"}, 32'(stats_valid), 32'd1);
      check({tag, "_qsize"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_avg"},   32'(avg_out),  32'(e[28:21]));
         check({tag, "_peak"},  32'(peak_out), 32'(e[20:13]));
         check({tag, "_min"},   32'(min_out),  32'(e[12:5]));
         check({tag, "_cnt"},   32'(over_cnt), 32'(e[4:1]));
         check({tag, "_alarm"}, 32'(alarm),    32'(e[0]));
      end
   endtask

   initial begin
      rst = 1'b1; mag_in = 8'd0; mag_valid = 1'b0; thresh = 8'd0; stats_ready = 1'b0;
      model_clear();
      m_alarm = 1'b0;
      idle(2);
      rst = 1'b0;
      check("rst_valid",   32'(stats_valid), 32'd0);
      check("rst_avg",     32'(avg_out),     32'd0);
      check("rst_peak",    32'(peak_out),    32'd0);
      check("rst_min",     32'(min_out),     32'd0);
      check("rst_cnt",     32'(over_cnt),    32'd0);
      check("rst_overrun", 32'(overrun),     32'd0);
      check("rst_alarm",   32'(alarm),       32'd0);

      // Ramp 0..7, back-to-back, consumer always ready.
      thresh = 8'd4;
      stats_ready = 1'b1;
      for (int i = 0; i < WIN; i++) send(8'(i));
      check_result("ramp");
      idle(1);
      check("ramp_pulse", 32'(stats_valid), 32'd0);

      // Full-scale samples with random gaps.
      thresh = 8'd255;
      for (int i = 0; i < WIN; i++) begin
         idle($urandom_range(0, 3));
         send(8'd255);
      end
      check_result("full");
      idle(1);

      // Stalled consumer across two windows.
      stats_ready = 1'b0;
      for (int i = 0; i < WIN; i++) send(8'd10);
      check_result("stall1");
      idle(3);
      check("stall1_hold", 32'(avg_out), 32'd10);
      for (int i = 0; i < WIN; i++) send(8'd20);
      check_result("stall2");
      check("stall2_overrun", 32'(overrun), 32'd1);
      stats_ready = 1'b1;
      idle(1);
      stats_ready = 1'b0;
      check("drain_valid",   32'(stats_valid), 32'd0);
      check("drain_overrun", 32'(overrun),     32'd0);

      // Handshake on the same edge as a window completing.
      for (int i = 0; i < WIN; i++) send(8'd30);
      check_result("same1");
      for (int i = 0; i < WIN - 1; i++) send(8'd40);
      stats_ready = 1'b1;
      send(8'd40);
      check_result("same2");
      check("same2_overrun", 32'(overrun), 32'd0);
      idle(1);
      check("same2_drain", 32'(stats_valid), 32'd0);

      // Reset mid-window discards the partial window.
      thresh = 8'd5;
      for (int i = 0; i < 5; i++) send(8'd250);
      do_reset();
      check("midrst_valid", 32'(stats_valid), 32'd0);
      for (int i = 1; i <= WIN; i++) send(8'(i));
      check_result("midrst");
      idle(1);

      // Alarm sequence: window averages 100, 98, 95 against thresh 100.
      thresh = 8'd100;
      for (int i = 0; i < WIN; i++) send(8'd100);
      check_result("alarm100");
      idle(1);
      for (int i = 0; i < WIN; i++) send(8'd98);
      check_result("alarm98");
      idle(1);
      for (int i = 0; i < WIN; i++) send(8'd95);
      check_result("alarm95");
      idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
